synth_period_timer: RTL and testbench
=====================================

# synth_period_timer

Period-measurement timer in FPGA fabric that sits directly upstream of the 24-bit HPS-readable timer PIO. It synchronizes an asynchronous event strobe (e.g. codec LRCLK or a note-gate edge) and counts prescaled clock ticks between successive rising edges. It presents the last complete period as a stable 24-bit value on `timer_out`, which connects straight to the PIO `in_port`. Software reads the PIO at any time and always sees a coherent, fully captured period.

## Interface
Parameters:
- `WIDTH`, 24: counter and output width; must match the PIO input width.
- `PRESCALE`, 1: clk cycles per count tick, ≥1.
- `SYNC_STAGES`, 2: synchronizer flops on `event_in`, ≥2.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  measurement enable, level.
- `clear`  in  1  synchronous one-cycle clear pulse.
- `event_in`  in  1  asynchronous event strobe; rising edge marks a period boundary.
- `timer_out`  out  WIDTH  last captured period in ticks; connects to the PIO `in_port`.
- `valid`  out  1  at least one full period has been captured since reset or clear.
- `capture`  out  1  one-cycle pulse when `timer_out` updates.
- `overflow`  out  1  sticky: a period saturated.

## Operation
- `event_in` passes through `SYNC_STAGES` flops plus one edge register. `evt` is high for one cycle per rising edge.
- The prescaler counts 0..PRESCALE-1. `tick` is high when it equals PRESCALE-1 and the FSM is in MEASURE.
- `cnt_next` = `cnt` + `tick`, saturating at 2^WIDTH-1.
- FSM states are IDLE, ARMED and MEASURE.
  - IDLE: `cnt` and the prescaler are held at 0. When `enable`=1, go to ARMED.
  - ARMED: when `evt` occurs, go to MEASURE with `cnt`<=0 and prescaler<=0. No capture is made; the first edge only starts timing.
  - MEASURE: `cnt`<=`cnt_next` every cycle.
  - MEASURE with `evt`: `timer_out`<=`cnt_next`, `capture`=1, `valid`<=1, `cnt`<=0, prescaler<=0. The FSM stays in MEASURE.
  - Any state with `enable`=0: go to IDLE. `timer_out`, `valid` and `overflow` hold their values.
- Saturation: when `cnt_next` reaches all-ones, `cnt` stays there and `overflow`<=1. The capture then yields all-ones.
- `clear` has priority over `evt`. It sets `timer_out`<=0, `valid`<=0 and `overflow`<=0. It sends the FSM to ARMED if `enable`=1, otherwise to IDLE.
- `evt` and a prescaler wrap in the same cycle: the tick is counted into the capture and the prescaler then restarts at 0.
- `evt` while the FSM is in IDLE is ignored.

## Timing
- Reset values: `timer_out`=0, `valid`=0, `capture`=0, `overflow`=0, FSM=IDLE. All counters and synchronizer flops are 0.
- Latency: `event_in` sampled high at edge k gives `evt` in cycle k+SYNC_STAGES. `timer_out` and `capture` are registered at the end of that cycle.
- Edges less than 2 clk apart at the synchronizer output merge into one edge. `event_in` must stay high and low for ≥2 clk each.
- Events exactly N·PRESCALE clk apart capture N. If N ≥ 2^WIDTH, the capture is all-ones and `overflow`=1.
- `timer_out` changes only on the cycle `capture` is high, or on `clear`. The PIO read register therefore samples a stable word.
- `reset_n` asserted mid-period discards the partial count immediately (async). The first edge after release only arms timing.

## Structure
- Package `synth_timer_pkg`:
  - FSM state enum.
  - Default constants `TIMER_WIDTH`=24, `TIMER_SYNC`=2.
  - Saturated all-ones constant helper.
- Sub-module `sync_edge_detect`: parameterized flop chain plus rising-edge pulse. It is reused for other asynchronous synth inputs.
- Top level: prescaler, counter, FSM, capture registers.

## Test plan
- Reset, then `enable`=1 with no events: `timer_out`=0, `valid`=0 indefinitely.
- PRESCALE=1, edges 100 clk apart:
  - First edge gives no capture.
  - Second edge gives `timer_out`=100, `capture` pulse SYNC_STAGES cycles after the sampled edge, `valid`=1.
  - Steady state holds at 100.
- PRESCALE=4, edges 4000 clk apart: `timer_out`=1000. Edges 4002 apart still give 1000.
- WIDTH=8, PRESCALE=1, edges 300 apart: `timer_out`=255, `overflow`=1. Then edges 50 apart give 50 with `overflow` still 1. `clear` resets all three outputs.
- `clear` and `evt` in the same cycle: outputs go to 0, FSM goes to ARMED, and no capture occurs. The next two edges 64 apart give 64.
- `enable` dropped mid-period, then raised: `timer_out` holds its old value. The first edge after re-enable only arms timing. `reset_n` pulse mid-period: all outputs go to 0 immediately.

Source files
------------

// File: rtl/synth_timer_pkg.sv
// Shared types and constants for the synth period timer.
// Also provides the saturation helper used by the counter.
package synth_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE
  } state_e;

  localparam int TIMER_WIDTH = 24;
  localparam int TIMER_SYNC  = 2;

  // All-ones value for a counter of width w (w <= 32).
  function automatic logic [31:0] sat_ones(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a one-cycle rising-edge pulse.
// Reused for any asynchronous synth control input.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/synth_period_timer.sv
// Measures prescaled ticks between event edges and holds the
// last complete period stable for the HPS timer PIO.
module synth_period_timer
  import synth_timer_pkg::*;
#(
  parameter int WIDTH       = TIMER_WIDTH,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = TIMER_SYNC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             event_in,
  output logic [WIDTH-1:0] timer_out,
  output logic             valid,
  output logic             capture,
  output logic             overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_ones(WIDTH));
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic [WIDTH-1:0] tout_q, tout_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             valid_q, valid_d;
  logic             cap_q, cap_d;
  logic             ovf_q, ovf_d;
  logic             evt, tick;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(event_in),
    .rise_o (evt)
  );

  assign tick = (state_q == ST_MEASURE) && (ps_q == PS_LAST);
  assign cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX
                  : cnt_q + WIDTH'(tick);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    tout_d  = tout_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    cap_d   = 1'b0;
    if (clear) begin
      state_d = enable ? ST_ARMED : ST_IDLE;
      cnt_d   = '0;
      ps_d    = '0;
      tout_d  = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ps_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          ps_d    = '0;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          cnt_d = '0;
          ps_d  = '0;
          if (evt) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          cnt_d = cnt_next;
          ps_d  = tick ? '0 : ps_q + 1'b1;
          if (cnt_next == CNT_MAX) ovf_d = 1'b1;
          // Closing edge also opens the next period.
          if (evt) begin
            tout_d  = cnt_next;
            cap_d   = 1'b1;
            valid_d = 1'b1;
            cnt_d   = '0;
            ps_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ps_q    <= '0;
      tout_q  <= '0;
      valid_q <= 1'b0;
      cap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
      cap_q   <= cap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign timer_out = tout_q;
  assign valid     = valid_q;
  assign capture   = cap_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_synth_period_timer.sv
// Directed bench for synth_period_timer across three
// configurations: 24b/presc 1, 24b/presc 4, 8b/presc 1.
module tb_synth_period_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  ev = '0;
  logic [23:0] t1, t4;
  logic [7:0]  t8;
  logic        v1, v4, v8;
  logic        c1, c4, c8;
  logic        o1, o4, o8;
  logic [2:0]  cap_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign cap_v = {c8, c4, c1};

  synth_period_timer #(
    .WIDTH(24), .PRESCALE(1), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .clear(clear), .event_in(ev[0]), .timer_out(t1),
    .valid(v1), .capture(c1), .overflow(o1)
  );

  synth_period_timer #(
    .WIDTH(24), .PRESCALE(4), .SYNC_STAGES(2)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .clear(clear), .event_in(ev[1]), .timer_out(t4),
    .valid(v4), .capture(c4), .overflow(o4)
  );

  synth_period_timer #(
    .WIDTH(8), .PRESCALE(1), .SYNC_STAGES(2)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .clear(clear), .event_in(ev[2]), .timer_out(t8),
    .valid(v8), .capture(c8), .overflow(o8)
  );

  // Raise event sel now (at a negedge), hold high 4 clk, then low
  // until gap clk have passed. Reports capture pulses seen and the
  // negedge index of the first one (3 = sampled edge + 2 clk).
  task automatic pulse(input int sel, input int gap, input int clr_at,
                       output int ncap, output int capi);
    ncap = 0;
    capi = -1;
    ev[sel] = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (cap_v[sel]) begin
        ncap++;
        if (capi < 0) capi = i;
      end
      if (i == 4) ev[sel] = 1'b0;
      clear = (i == clr_at);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (t1 !== 24'd0) begin errors++; $display("FAIL reset_timer: got %0d want 0", t1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v1); end
    checks++; if (c1 !== 1'b0) begin errors++; $display("FAIL reset_capture: got %b want 0", c1); end
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", o1); end
    checks++; if (t8 !== 8'd0) begin errors++; $display("FAIL reset_timer8: got %0d want 0", t8); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_no_events();
    int caps;
    caps = 0;
    enable = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (c1) caps++;
    end
    checks++; if (t1 !== 24'd0) begin errors++; $display("FAIL idle_timer: got %0d want 0", t1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", v1); end
    checks++; if (caps !== 0) begin errors++; $display("FAIL idle_capture: got %0d pulses want 0", caps); end
  endtask

  task automatic test_prescale1();
    int n, ci;
    pulse(0, 100, -1, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL p1_first_nocap: got %0d pulses want 0", n); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL p1_first_valid: got %b want 0", v1); end
    pulse(0, 100, -1, n, ci);
    checks++; if (n !== 1) begin errors++; $display("FAIL p1_cap_count: got %0d want 1", n); end
    checks++; if (ci !== 3) begin errors++; $display("FAIL p1_cap_latency: got %0d want 3", ci); end
    checks++; if (t1 !== 24'd100) begin errors++; $display("FAIL p1_value: got %0d want 100", t1); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL p1_valid: got %b want 1", v1); end
    pulse(0, 100, -1, n, ci);
    checks++; if (t1 !== 24'd100) begin errors++; $display("FAIL p1_steady: got %0d want 100", t1); end
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL p1_overflow: got %b want 0", o1); end
  endtask

  task automatic test_clear_evt();
    int n, ci;
    pulse(0, 64, 2, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL clr_evt_nocap: got %0d pulses want 0", n); end
    checks++; if (t1 !== 24'd0) begin errors++; $display("FAIL clr_evt_timer: got %0d want 0", t1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL clr_evt_valid: got %b want 0", v1); end
    pulse(0, 64, -1, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL clr_evt_arm: got %0d pulses want 0", n); end
    pulse(0, 64, -1, n, ci);
    checks++; if (t1 !== 24'd64) begin errors++; $display("FAIL clr_evt_64: got %0d want 64", t1); end
    checks++; if (n !== 1) begin errors++; $display("FAIL clr_evt_cap: got %0d want 1", n); end
  endtask

  task automatic test_enable_reset();
    int n, ci;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (t1 !== 24'd64) begin errors++; $display("FAIL en_hold_timer: got %0d want 64", t1); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL en_hold_valid: got %b want 1", v1); end
    pulse(0, 40, -1, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL en_rearm: got %0d pulses want 0", n); end
    checks++; if (t1 !== 24'd64) begin errors++; $display("FAIL en_rearm_hold: got %0d want 64", t1); end
    pulse(0, 40, -1, n, ci);
    checks++; if (t1 !== 24'd40) begin errors++; $display("FAIL en_40: got %0d want 40", t1); end
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (t1 !== 24'd0) begin errors++; $display("FAIL rst_async_timer: got %0d want 0", t1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", v1); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse(0, 40, -1, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_rearm: got %0d pulses want 0", n); end
    pulse(0, 40, -1, n, ci);
    checks++; if (t1 !== 24'd40) begin errors++; $display("FAIL rst_40: got %0d want 40", t1); end
  endtask

  task automatic test_prescale4();
    int n, ci;
    pulse(1, 4000, -1, n, ci);
    checks++; if (n !== 0) begin errors++; $display("FAIL p4_first: got %0d pulses want 0", n); end
    pulse(1, 4000, -1, n, ci);
    checks++; if (t4 !== 24'd1000) begin errors++; $display("FAIL p4_1000: got %0d want 1000", t4); end
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL p4_valid: got %b want 1", v4); end
    pulse(1, 4002, -1, n, ci);
    checks++; if (t4 !== 24'd1000) begin errors++; $display("FAIL p4_steady: got %0d want 1000", t4); end
    pulse(1, 10, -1, n, ci);
    checks++; if (t4 !== 24'd1000) begin errors++; $display("FAIL p4_4002: got %0d want 1000", t4); end
  endtask

  task automatic test_overflow();
    int n, ci;
    pulse(2, 300, -1, n, ci);
    pulse(2, 50, -1, n, ci);
    checks++; if (t8 !== 8'd255) begin errors++; $display("FAIL ovf_sat: got %0d want 255", t8); end
    checks++; if (o8 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o8); end
    pulse(2, 50, -1, n, ci);
    checks++; if (t8 !== 8'd50) begin errors++; $display("FAIL ovf_50: got %0d want 50", t8); end
    checks++; if (o8 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o8); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (t8 !== 8'd0) begin errors++; $display("FAIL ovf_clr_timer: got %0d want 0", t8); end
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL ovf_clr_valid: got %b want 0", v8); end
    checks++; if (o8 !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag: got %b want 0", o8); end
  endtask

  initial begin
    test_reset();
    test_enable_no_events();
    test_prescale1();
    test_clear_evt();
    test_enable_reset();
    test_prescale4();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
